maxnet_controller: RTL

MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

---
 rtl/maxnet_pkg.sv | 19 +
 rtl/maxnet_controller_cycle_counter.sv | 36 +++
 rtl/maxnet_controller.sv | 116 +++++++++++
 3 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and defaults for the MAXNET competition controller.
// Holds the FSM encoding, parameter defaults and counter widths.
package maxnet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_CHECK,
    ST_UPDATE,
    ST_DONE
  } state_e;

  localparam int unsigned PU_LATENCY_DEF = 2;
  localparam int unsigned MAX_ITER_DEF   = 64;
  localparam int unsigned ITER_W         = 8;
  localparam int unsigned WAIT_W         = 4;

endpackage

// File: rtl/maxnet_controller_cycle_counter.sv
// Loadable down-counter timing the WAIT state.
// Holds at zero; expired flags the final cycle.
module cycle_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer for the four-neuron MAXNET datapath: loads X,
// then iterates PU updates until one winner or MAX_ITER.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int unsigned PU_LATENCY = PU_LATENCY_DEF,
  parameter int unsigned MAX_ITER   = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_finished,
  output logic              load_a,
  output logic              load_sel,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);
  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(PU_LATENCY - 1);

  state_e            state_q;
  state_e            state_d;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] iter_d;
  logic              timeout_q;
  logic              timeout_d;
  logic              wc_load;
  logic              wc_dec;
  logic              wc_expired;

  // Loaded on the way into WAIT so WAIT spans PU_LATENCY cycles.
  cycle_counter #(
    .W(WAIT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (wc_load),
    .load_val(WAIT_LD),
    .dec     (wc_dec),
    .expired (wc_expired)
  );

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    wc_load   = 1'b0;
    wc_dec    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        iter_d    = '0;
        timeout_d = 1'b0;
        wc_load   = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (wc_expired) begin
          state_d = ST_CHECK;
        end else begin
          wc_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        if (is_finished) begin
          state_d = ST_DONE;
        end else if (iter_q == MAX_CNT) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (iter_q != MAX_CNT) begin
          iter_d = iter_q + 1'b1;
        end
        wc_load = 1'b1;
        state_d = ST_WAIT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      iter_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
    end
  end

  assign load_a     = (state_q == ST_INIT) || (state_q == ST_UPDATE);
  assign load_sel   = (state_q == ST_INIT);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign timeout    = timeout_q;
  assign iter_count = iter_q;

endmodule
